pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DW, default 32, width of each payload word (ALU result, store data).
REQ-002 Parameter CW, default 3, width of control vector (wreg, m2reg, wmem); forced to zero in bubbles.
REQ-003 Parameter RW, default 5, width of destination register number.
REQ-004 Parameter SKID, default 1; 1 = two-entry skid mode, 0 = single-entry stall mode.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 clrn  in  1  asynchronous active-low reset.
REQ-007 flush  in  1  synchronous cancel (interrupt/exception); kills all held entries.
REQ-008 in_valid  in  1  upstream stage holds a valid instruction.
REQ-009 in_ready  out  1  stage accepts input this cycle.
REQ-010 in_ctl  in  CW  upstream control bits.
REQ-011 in_alu, in_b  in  DW each  upstream payload words.
REQ-012 in_rn  in  RW  upstream destination register number.
REQ-013 out_valid  out  1  stage holds a valid instruction.
REQ-014 out_ready  in  1  downstream accepts output this cycle.
REQ-015 out_ctl, out_alu, out_b, out_rn  out  CW/DW/DW/RW  held entry fields.
REQ-016 count  out  2  number of held entries (0..2).

Function
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 Outputs always driven from the main entry; out_ctl SHALL be zero whenever out_valid = 0.
REQ-019 Latency: an entry accepted at edge N appears on outputs after edge N when the stage was empty or draining (one cycle).
REQ-020 SKID=1 states: EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-021 EMPTY: in_fire -> ONE, main loaded.
REQ-022 ONE: in_fire & out_fire -> ONE, main reloaded; in_fire & !out_fire -> FULL, skid loaded; !in_fire & out_fire -> EMPTY, main ctl cleared; neither -> hold.
REQ-023 FULL: in_ready = 0; out_fire -> ONE, skid moves to main; else hold.
REQ-024 SKID=1: in_ready SHALL be a registered signal, 1 exactly when state != FULL; no combinational path out_ready -> in_ready.
REQ-025 SKID=0: single main entry; in_ready = out_ready | !out_valid (combinational); count never exceeds 1.
REQ-026 Entry order SHALL be preserved; no entry duplicated or dropped except by flush.
REQ-027 flush SHALL override all other events: next state EMPTY, count 0, all ctl fields zeroed, the in_fire entry of that cycle discarded; in_ready may still read 1 that cycle.
REQ-028 Payload fields (alu, b, rn) of discarded or drained entries may hold stale values; only ctl and valid are cleared.
REQ-029 Holding (out_valid & !out_ready) SHALL keep all out_* fields stable.

Reset
REQ-030 clrn = 0 SHALL immediately set state EMPTY, out_valid 0, count 0, all ctl, alu, b, rn fields (main and skid) to 0.
REQ-031 After reset release in_ready SHALL be 1 in both modes.
REQ-032 Reset asserted mid-transfer SHALL discard both entries without a partial write.

Structure
REQ-033 State encoding constants (EMPTY/ONE/FULL) SHALL live in the shared pipeline package.
REQ-034 One sub-module, pipe_entry (enable-loaded, clear-able ctl/payload register, async clrn), instantiated for main and skid entries; skid instance omitted when SKID=0.

Verification
REQ-035 Reset, then in_valid=1, in_ctl=3'b101, in_alu=32'h1234, out_ready=1 -> next cycle out_valid=1, out_ctl=3'b101, out_alu=32'h1234, count=1.
REQ-036 SKID=1, out_ready=0, push A then B -> count=2, in_ready=0, out_alu=A; raise out_ready -> A then B on consecutive cycles, then out_valid=0, out_ctl=0.
REQ-037 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, out_ctl=0, in_ready=1; flushed input never appears.
REQ-038 Stream 100 entries with out_ready toggling pseudo-randomly -> output sequence equals input sequence, no loss or duplication.
REQ-039 SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, replacement loaded at next edge.
REQ-040 clrn pulsed low between clock edges with count=2 -> outputs zero immediately, in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: occupancy state encoding for pipeline stage registers.
// Each state's encoding equals the number of held entries.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: enable-loaded control/payload register.
// Clearing zeroes only the control bits; the payload keeps its stale value.
module pipe_entry #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 3,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_load,
  input  logic          i_clr,
  input  logic [CW-1:0] i_ctl,
  input  logic [DW-1:0] i_alu,
  input  logic [DW-1:0] i_b,
  input  logic [RW-1:0] i_rn,
  output logic [CW-1:0] o_ctl,
  output logic [DW-1:0] o_alu,
  output logic [DW-1:0] o_b,
  output logic [RW-1:0] o_rn
);

  logic [CW-1:0] r_ctl;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_b;
  logic [RW-1:0] r_rn;

  // Clear wins over load, so a cancelled entry can never leave live control bits.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ctl <= '0;
      r_alu <= '0;
      r_b   <= '0;
      r_rn  <= '0;
    end else if (i_clr) begin
      r_ctl <= '0;
    end else if (i_load) begin
      r_ctl <= i_ctl;
      r_alu <= i_alu;
      r_b   <= i_b;
      r_rn  <= i_rn;
    end
  end

  assign o_ctl = r_ctl;
  assign o_alu = r_alu;
  assign o_b   = r_b;
  assign o_rn  = r_rn;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional skid entry.
// With the skid entry present, in_ready is registered, which breaks the ready path.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CW   = 3,
  parameter int unsigned RW   = 5,
  parameter int unsigned SKID = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctl,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_b,
  input  logic [RW-1:0] in_rn,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctl,
  output logic [DW-1:0] out_alu,
  output logic [DW-1:0] out_b,
  output logic [RW-1:0] out_rn,
  output logic [1:0]    count
);

  stage_state_e  r_state;
  stage_state_e  w_state_next;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_main_load;
  logic          w_main_clr;
  logic          w_skid_load;
  logic          w_skid_clr;
  logic          w_from_skid;
  logic [CW-1:0] w_skid_ctl;
  logic [DW-1:0] w_skid_alu;
  logic [DW-1:0] w_skid_b;
  logic [RW-1:0] w_skid_rn;

  assign w_out_valid = (r_state != StEmpty);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Without a skid entry, ONE with in_fire always has out_fire, so FULL is unreachable.
  always_comb begin
    w_state_next = r_state;
    w_main_load  = 1'b0;
    w_main_clr   = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clr   = 1'b0;
    w_from_skid  = 1'b0;
    if (flush) begin
      w_state_next = StEmpty;
      w_main_clr   = 1'b1;
      w_skid_clr   = 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_next = StOne;
            w_main_load  = 1'b1;
          end
        end
        StOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_state_next = StFull;
            w_skid_load  = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = StEmpty;
            w_main_clr   = 1'b1;
          end
        end
        StFull: begin
          if (w_out_fire) begin
            w_state_next = StOne;
            w_main_load  = 1'b1;
            w_from_skid  = 1'b1;
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  pipe_entry #(
    .DW(DW),
    .CW(CW),
    .RW(RW)
  ) u_main (
    .clk    (clk),
    .clrn   (clrn),
    .i_load (w_main_load),
    .i_clr  (w_main_clr),
    .i_ctl  (w_from_skid ? w_skid_ctl : in_ctl),
    .i_alu  (w_from_skid ? w_skid_alu : in_alu),
    .i_b    (w_from_skid ? w_skid_b : in_b),
    .i_rn   (w_from_skid ? w_skid_rn : in_rn),
    .o_ctl  (out_ctl),
    .o_alu  (out_alu),
    .o_b    (out_b),
    .o_rn   (out_rn)
  );

  if (SKID != 0) begin : g_skid
    logic r_in_ready;

    pipe_entry #(
      .DW(DW),
      .CW(CW),
      .RW(RW)
    ) u_skid (
      .clk    (clk),
      .clrn   (clrn),
      .i_load (w_skid_load),
      .i_clr  (w_skid_clr),
      .i_ctl  (in_ctl),
      .i_alu  (in_alu),
      .i_b    (in_b),
      .i_rn   (in_rn),
      .o_ctl  (w_skid_ctl),
      .o_alu  (w_skid_alu),
      .o_b    (w_skid_b),
      .o_rn   (w_skid_rn)
    );

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        r_in_ready <= 1'b1;
      end else begin
        r_in_ready <= (w_state_next != StFull);
      end
    end

    assign w_in_ready = r_in_ready;
  end else begin : g_no_skid
    logic w_unused_skid;

    assign w_skid_ctl    = '0;
    assign w_skid_alu    = '0;
    assign w_skid_b      = '0;
    assign w_skid_rn     = '0;
    assign w_unused_skid = w_skid_load ^ w_skid_clr;
    assign w_in_ready    = out_ready | ~w_out_valid;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a single-entry and a skid instance run side by side,
// each tracked by an in-order FIFO model of the entries it must currently hold.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [2:0]  ctl;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } ent_t;

  logic        clk = 1'b0;
  logic        clrn;
  logic        flush     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [2:0]  in_ctl    [2];
  logic [31:0] in_alu    [2];
  logic [31:0] in_b      [2];
  logic [4:0]  in_rn     [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [2:0]  out_ctl   [2];
  logic [31:0] out_alu   [2];
  logic [31:0] out_b     [2];
  logic [4:0]  out_rn    [2];
  logic [1:0]  count     [2];

  int   checks   = 0;
  int   failures = 0;
  ent_t mq [2][4];
  int   mn [2];
  int   pops [2];
  logic rdy1;
  int   seq = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(32), .CW(3), .RW(5), .SKID(0)) u_dut0 (
    .clk(clk), .clrn(clrn), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctl(in_ctl[0]),
    .in_alu(in_alu[0]), .in_b(in_b[0]), .in_rn(in_rn[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctl(out_ctl[0]),
    .out_alu(out_alu[0]), .out_b(out_b[0]), .out_rn(out_rn[0]), .count(count[0])
  );

  pipe_stage_reg #(.DW(32), .CW(3), .RW(5), .SKID(1)) u_dut1 (
    .clk(clk), .clrn(clrn), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctl(in_ctl[1]),
    .in_alu(in_alu[1]), .in_b(in_b[1]), .in_rn(in_rn[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctl(out_ctl[1]),
    .out_alu(out_alu[1]), .out_b(out_b[1]), .out_rn(out_rn[1]), .count(count[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int m, input logic v, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic ordy,
                        input logic fl);
    in_valid[m]  = v;
    in_ctl[m]    = c;
    in_alu[m]    = a;
    in_b[m]      = b;
    in_rn[m]     = r;
    out_ready[m] = ordy;
    flush[m]     = fl;
  endtask

  task automatic set_all(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic ordy, input logic fl);
    for (int m = 0; m < 2; m++) set_in(m, v, c, a, ~a, a[4:0], ordy, fl);
  endtask

  function automatic logic exp_rdy(input int m);
    if (m == 1) return rdy1;
    return out_ready[0] | (mn[0] == 0);
  endfunction

  task automatic model_clear();
    mn[0] = 0;
    mn[1] = 0;
    rdy1  = 1'b1;
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      logic v;
      v = (mn[m] != 0);
      chk($sformatf("out_valid[%0d]", m), 32'(out_valid[m]), 32'(v));
      chk($sformatf("count[%0d]", m), 32'(count[m]), 32'(mn[m]));
      chk($sformatf("in_ready[%0d]", m), 32'(in_ready[m]), 32'(exp_rdy(m)));
      chk($sformatf("out_ctl[%0d]", m), 32'(out_ctl[m]), v ? 32'(mq[m][0].ctl) : 32'd0);
      if (v) begin
        chk($sformatf("out_alu[%0d]", m), out_alu[m], mq[m][0].alu);
        chk($sformatf("out_b[%0d]", m), out_b[m], mq[m][0].b);
        chk($sformatf("out_rn[%0d]", m), 32'(out_rn[m]), 32'(mq[m][0].rn));
      end
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    logic inf [2];
    logic outf [2];
    #1 compare_all();
    for (int m = 0; m < 2; m++) begin
      inf[m]  = in_valid[m] & exp_rdy(m);
      outf[m] = (mn[m] != 0) & out_ready[m];
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (flush[m]) begin
        mn[m] = 0;
      end else begin
        if (outf[m]) begin
          for (int i = 0; i < 3; i++) mq[m][i] = mq[m][i+1];
          mn[m]--;
          pops[m]++;
        end
        if (inf[m]) begin
          mq[m][mn[m]] = '{ctl: in_ctl[m], alu: in_alu[m], b: in_b[m], rn: in_rn[m]};
          mn[m]++;
        end
      end
    end
    rdy1 = (mn[1] != 2);
    @(negedge clk);
  endtask

  task automatic rand_cycles(input int n, input bit with_flush);
    for (int k = 0; k < n; k++) begin
      for (int m = 0; m < 2; m++) begin
        seq++;
        set_in(m, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), {m[3:0], 28'(seq)},
               $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               with_flush && ($urandom_range(0, 19) == 0));
      end
      cycle();
    end
  endtask

  initial begin
    clrn = 1'b0;
    set_all(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    model_clear();
    pops[0] = 0;
    pops[1] = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("reset out_valid", 32'(out_valid[m]), 32'd0);
      chk("reset count", 32'(count[m]), 32'd0);
      chk("reset out_ctl", 32'(out_ctl[m]), 32'd0);
      chk("reset out_alu", out_alu[m], 32'd0);
    end
    clrn = 1'b1;
    #1;
    chk("release in_ready0", 32'(in_ready[0]), 32'd1);
    chk("release in_ready1", 32'(in_ready[1]), 32'd1);
    @(negedge clk);

    // First transfer: one-cycle latency.
    set_all(1'b1, 3'b101, 32'h1234, 1'b1, 1'b0);
    cycle();
    chk("first out_valid", 32'(out_valid[1]), 32'd1);
    chk("first out_ctl", 32'(out_ctl[1]), 32'd5);
    chk("first out_alu", out_alu[1], 32'h1234);
    chk("first count", 32'(count[1]), 32'd1);
    set_all(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    cycle();

    // Skid fill with a stalled consumer, then drain in order.
    set_all(1'b1, 3'b001, 32'hA0A0, 1'b0, 1'b0);
    cycle();
    set_all(1'b1, 3'b110, 32'hB0B0, 1'b0, 1'b0);
    cycle();
    chk("skid count", 32'(count[1]), 32'd2);
    chk("skid in_ready", 32'(in_ready[1]), 32'd0);
    chk("skid head", out_alu[1], 32'hA0A0);
    set_all(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    chk("drain second", out_alu[1], 32'hB0B0);
    cycle();
    chk("drained valid", 32'(out_valid[1]), 32'd0);
    chk("drained ctl", 32'(out_ctl[1]), 32'd0);

    // Flush while full with a concurrent input.
    set_all(1'b1, 3'b011, 32'hC0C0, 1'b0, 1'b0);
    cycle();
    set_all(1'b1, 3'b111, 32'hD0D0, 1'b0, 1'b0);
    cycle();
    set_all(1'b1, 3'b111, 32'hE0E0, 1'b0, 1'b1);
    cycle();
    chk("flush count", 32'(count[1]), 32'd0);
    chk("flush valid", 32'(out_valid[1]), 32'd0);
    chk("flush ctl", 32'(out_ctl[1]), 32'd0);
    chk("flush in_ready", 32'(in_ready[1]), 32'd1);
    set_all(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Single-entry mode: in_ready follows out_ready combinationally.
    set_all(1'b1, 3'b010, 32'hF0F0, 1'b0, 1'b0);
    cycle();
    set_all(1'b1, 3'b100, 32'h6060, 1'b0, 1'b0);
    #1 chk("stall in_ready0", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    #1 chk("go in_ready0", 32'(in_ready[0]), 32'd1);
    cycle();
    chk("replace out_alu0", out_alu[0], 32'h6060);
    set_all(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    cycle();

    rand_cycles(400, 1'b0);
    chk("stream0 >=100", 32'(pops[0] >= 100), 32'd1);
    chk("stream1 >=100", 32'(pops[1] >= 100), 32'd1);
    rand_cycles(300, 1'b1);

    // Asynchronous reset between edges while full.
    set_all(1'b0, 3'd0, 32'd0, 1'b1, 1'b0);
    cycle();
    cycle();
    set_all(1'b1, 3'b101, 32'h1111, 1'b0, 1'b0);
    cycle();
    set_all(1'b1, 3'b110, 32'h2222, 1'b0, 1'b0);
    cycle();
    chk("pre-reset count", 32'(count[1]), 32'd2);
    #2 clrn = 1'b0;
    #1;
    chk("async valid", 32'(out_valid[1]), 32'd0);
    chk("async count", 32'(count[1]), 32'd0);
    chk("async ctl", 32'(out_ctl[1]), 32'd0);
    chk("async alu", out_alu[1], 32'd0);
    model_clear();
    set_all(1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    clrn = 1'b1;
    #1;
    chk("post-reset in_ready1", 32'(in_ready[1]), 32'd1);
    chk("post-reset in_ready0", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rand_cycles(50, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
